// File: rtl/passwd_checker.sv
// Six-digit keypad lock controller: entry buffer, compare, failure lockout, password capture.
// Optional feature macro: CHANGE_PASSWD_EN (SET state, d1..d6 and pw_load).
module passwd_checker #(
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          key_valid,
    input  logic [3:0]                    key_code,
    input  logic [3:0]                    p1,
    input  logic [3:0]                    p2,
    input  logic [3:0]                    p3,
    input  logic [3:0]                    p4,
    input  logic [3:0]                    p5,
    input  logic [3:0]                    p6,
    output logic [3:0]                    d1,
    output logic [3:0]                    d2,
    output logic [3:0]                    d3,
    output logic [3:0]                    d4,
    output logic [3:0]                    d5,
    output logic [3:0]                    d6,
    output logic                          pw_load,
    output logic                          unlocked,
    output logic                          alarm,
    output logic [2:0]                    digit_cnt,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int TW = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [1:0] {LOCKED, UNLOCKED, SET, ALARM} state_t;

    state_t          r_state;
    logic [3:0]      r_buf [0:5];
    logic [2:0]      r_digit_cnt;
    logic [FW-1:0]   r_fail_cnt;
    logic [TW-1:0]   r_timer;
    logic            r_unlocked;
    logic            r_alarm;

    logic            w_is_digit;
    logic            w_room;
    logic            w_match;
    logic [FW-1:0]   w_fail_next;

    assign w_is_digit  = (key_code <= 4'd9);
    assign w_room      = (r_digit_cnt < 3'd6);
    assign w_fail_next = r_fail_cnt + {{(FW-1){1'b0}}, 1'b1};
    assign w_match     = (r_digit_cnt == 3'd6) &&
                         (r_buf[0] == p1) && (r_buf[1] == p2) && (r_buf[2] == p3) &&
                         (r_buf[3] == p4) && (r_buf[4] == p5) && (r_buf[5] == p6);

`ifdef CHANGE_PASSWD_EN
    logic [3:0]      r_new [0:5];
    logic            r_pw_load;
    assign d1 = r_new[0];
    assign d2 = r_new[1];
    assign d3 = r_new[2];
    assign d4 = r_new[3];
    assign d5 = r_new[4];
    assign d6 = r_new[5];
    assign pw_load = r_pw_load;
`else
    assign d1 = 4'h0;
    assign d2 = 4'h0;
    assign d3 = 4'h0;
    assign d4 = 4'h0;
    assign d5 = 4'h0;
    assign d6 = 4'h0;
    assign pw_load = 1'b0;
`endif

    assign unlocked  = r_unlocked;
    assign alarm     = r_alarm;
    assign digit_cnt = r_digit_cnt;
    assign fail_cnt  = r_fail_cnt;

    // Lock FSM: state, entry buffer, failure counter, lockout timer and registered outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= LOCKED;
            r_buf       <= '{default: 4'h0};
            r_digit_cnt <= 3'd0;
            r_fail_cnt  <= '0;
            r_timer     <= '0;
            r_unlocked  <= 1'b0;
            r_alarm     <= 1'b0;
`ifdef CHANGE_PASSWD_EN
            r_new       <= '{default: 4'h0};
            r_pw_load   <= 1'b0;
`endif
        end else begin
`ifdef CHANGE_PASSWD_EN
            r_pw_load <= 1'b0;
`endif
            case (r_state)
                LOCKED: begin
                    if (key_valid) begin
                        if (w_is_digit) begin
                            if (w_room) begin
                                r_buf[r_digit_cnt] <= key_code;
                                r_digit_cnt        <= r_digit_cnt + 3'd1;
                            end
                        end else if (key_code == 4'hB) begin
                            r_buf       <= '{default: 4'h0};
                            r_digit_cnt <= 3'd0;
                        end else if (key_code == 4'hA) begin
                            r_buf       <= '{default: 4'h0};
                            r_digit_cnt <= 3'd0;
                            if (w_match) begin
                                r_state    <= UNLOCKED;
                                r_unlocked <= 1'b1;
                                r_fail_cnt <= '0;
                            end else begin
                                r_fail_cnt <= w_fail_next;
                                if (w_fail_next == FW'(MAX_FAIL)) begin
                                    r_state <= ALARM;
                                    r_alarm <= 1'b1;
                                    r_timer <= TW'(LOCK_CYCLES - 1);
                                end
                            end
                        end
                    end
                end
                ALARM: begin
                    if (r_timer == '0) begin
                        r_state    <= LOCKED;
                        r_alarm    <= 1'b0;
                        r_fail_cnt <= '0;
                    end else begin
                        r_timer <= r_timer - {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                UNLOCKED: begin
                    if (key_valid) begin
                        if ((key_code == 4'hA) || (key_code == 4'hD)) begin
                            r_state     <= LOCKED;
                            r_unlocked  <= 1'b0;
                            r_buf       <= '{default: 4'h0};
                            r_digit_cnt <= 3'd0;
`ifdef CHANGE_PASSWD_EN
                        end else if (key_code == 4'hC) begin
                            r_state     <= SET;
                            r_buf       <= '{default: 4'h0};
                            r_digit_cnt <= 3'd0;
`endif
                        end
                    end
                end
`ifdef CHANGE_PASSWD_EN
                SET: begin
                    if (key_valid) begin
                        if (w_is_digit) begin
                            if (w_room) begin
                                r_buf[r_digit_cnt] <= key_code;
                                r_digit_cnt        <= r_digit_cnt + 3'd1;
                            end
                        end else if ((key_code == 4'hA) || (key_code == 4'hB)) begin
                            // Only a complete six-digit entry is offered to the password register.
                            if ((key_code == 4'hA) && (r_digit_cnt == 3'd6)) begin
                                r_new     <= r_buf;
                                r_pw_load <= 1'b1;
                            end
                            r_state     <= UNLOCKED;
                            r_buf       <= '{default: 4'h0};
                            r_digit_cnt <= 3'd0;
                        end else if (key_code == 4'hD) begin
                            r_state     <= LOCKED;
                            r_unlocked  <= 1'b0;
                            r_buf       <= '{default: 4'h0};
                            r_digit_cnt <= 3'd0;
                        end
                    end
                end
`endif
                default: begin
                    r_state     <= LOCKED;
                    r_unlocked  <= 1'b0;
                    r_alarm     <= 1'b0;
                    r_buf       <= '{default: 4'h0};
                    r_digit_cnt <= 3'd0;
                end
            endcase
        end
    end
endmodule
